// File: rtl/spacewar_pkg.sv
// Shared fixed-point widths, velocity limits, heading direction table and FSM states
// for the ship kinematics block and its wrap adders.
package spacewar_pkg;
    localparam int POS_INT_W  = 10;
    localparam int POS_FRAC_W = 4;
    localparam int POS_W      = POS_INT_W + POS_FRAC_W;
    localparam int VEL_W      = 8;
    localparam int TVEL_W     = 9;
    localparam int HDG_W      = 4;

    localparam logic signed [VEL_W-1:0] VEL_MIN = -8'sd64;
    localparam logic signed [VEL_W-1:0] VEL_MAX = 8'sd63;

    typedef enum logic [2:0] {
        S_IDLE, S_ROTATE, S_ACCEL, S_MOVE, S_TORP, S_DONE
    } state_t;

    typedef logic signed [3:0] dir_t;

    // 4*cos(h*22.5deg), rounded
    function automatic dir_t dir_dx(input logic [HDG_W-1:0] h);
        dir_t d;
        case (h)
            4'd0, 4'd1, 4'd15: d = 4'sd4;
            4'd2, 4'd14:       d = 4'sd3;
            4'd3, 4'd13:       d = 4'sd2;
            4'd4, 4'd12:       d = 4'sd0;
            4'd5, 4'd11:       d = -4'sd2;
            4'd6, 4'd10:       d = -4'sd3;
            default:           d = -4'sd4;
        endcase
        return d;
    endfunction

    // -4*sin(h*22.5deg), rounded: screen y grows downwards
    function automatic dir_t dir_dy(input logic [HDG_W-1:0] h);
        dir_t d;
        case (h)
            4'd3, 4'd4, 4'd5:    d = -4'sd4;
            4'd2, 4'd6:          d = -4'sd3;
            4'd1, 4'd7:          d = -4'sd2;
            4'd0, 4'd8:          d = 4'sd0;
            4'd9, 4'd15:         d = 4'sd2;
            4'd10, 4'd14:        d = 4'sd3;
            default:             d = 4'sd4;
        endcase
        return d;
    endfunction

    function automatic logic signed [VEL_W-1:0] vel_sat(input logic signed [VEL_W-1:0] v,
                                                         input dir_t d);
        logic signed [VEL_W:0] s;
        s = $signed({v[VEL_W-1], v}) + $signed({{(VEL_W-3){d[3]}}, d});
        if (s > $signed({1'b0, VEL_MAX}))      return VEL_MAX;
        else if (s < $signed({1'b1, VEL_MIN})) return VEL_MIN;
        else                                   return s[VEL_W-1:0];
    endfunction

    function automatic logic signed [TVEL_W-1:0] torp_vel(input dir_t d);
        return {d[3], d, 4'b0000};
    endfunction
endpackage

// File: rtl/ship_kinematics_if.sv
// Switch inputs, frame strobe and committed ship/torpedo state; master = game logic, slave = kinematics.
// Pure level/pulse signalling: no handshake, the frame strobe is dropped when the block is busy.
interface ship_kinematics_if import spacewar_pkg::*;;
    logic                 frame_done;
    logic                 rot_left;
    logic                 rot_right;
    logic                 thrust;
    logic                 fire;
    logic [POS_INT_W-1:0] ship_x;
    logic [POS_INT_W-1:0] ship_y;
    logic [HDG_W-1:0]     heading;
    logic [POS_INT_W-1:0] torp_x;
    logic [POS_INT_W-1:0] torp_y;
    logic                 torp_active;
    logic                 busy;
    logic                 update_done;

    modport master (
        output frame_done, rot_left, rot_right, thrust, fire,
        input  ship_x, ship_y, heading, torp_x, torp_y, torp_active, busy, update_done
    );
    modport slave (
        input  frame_done, rot_left, rot_right, thrust, fire,
        output ship_x, ship_y, heading, torp_x, torp_y, torp_active, busy, update_done
    );
endinterface

// File: rtl/wrap_adder.sv
// 10.4 position plus signed 1/16-pixel velocity with toroidal wrap at MAX pixels.
// Combinational, zero latency, no backpressure.
module wrap_adder import spacewar_pkg::*; #(
    parameter int MAX = 640
) (
    input  logic        [POS_W-1:0]  pos_i,
    input  logic signed [TVEL_W-1:0] vel_i,
    output logic        [POS_W-1:0]  pos_o
);
    localparam logic signed [POS_W:0] SPAN = $signed((POS_W+1)'(MAX * 16));

    logic signed [POS_W:0] sum;

    always_comb begin
        sum = $signed({1'b0, pos_i}) + $signed({{(POS_W+1-TVEL_W){vel_i[TVEL_W-1]}}, vel_i});
        if (sum >= SPAN)    pos_o = POS_W'(sum - SPAN);
        else if (sum[POS_W]) pos_o = POS_W'(sum + SPAN);
        else                pos_o = sum[POS_W-1:0];
    end
endmodule

// File: rtl/ship_kinematics.sv
// Per-frame ship/torpedo update: rotate, accelerate, move, torpedo, commit; frame strobe to update_done = 5 cycles.
// No backpressure: frame_done seen outside IDLE is dropped; outputs only change as DONE begins.
module ship_kinematics import spacewar_pkg::*; #(
    parameter int X_MAX     = 640,
    parameter int Y_MAX     = 480,
    parameter int START_X   = 320,
    parameter int START_Y   = 240,
    parameter int TORP_LIFE = 64
) (
    input logic              clk,
    input logic              rst,
    ship_kinematics_if.slave bus
);
    localparam int                LIFE_W    = $clog2(TORP_LIFE + 1);
    localparam logic [LIFE_W-1:0] LIFE_INIT = LIFE_W'(TORP_LIFE);
    localparam logic [LIFE_W-1:0] LIFE_ONE  = LIFE_W'(1);
    localparam logic [POS_W-1:0]  X0        = POS_W'(START_X * 16);
    localparam logic [POS_W-1:0]  Y0        = POS_W'(START_Y * 16);

    state_t                     state_q, state_d;
    logic        [HDG_W-1:0]    hdg_q, hdg_d;
    logic signed [VEL_W-1:0]    vel_x_q, vel_x_d, vel_y_q, vel_y_d;
    logic        [POS_W-1:0]    pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic                       fire_q, fire_d;
    logic                       t_act_q, t_act_d;
    logic        [POS_W-1:0]    t_x_q, t_x_d, t_y_q, t_y_d;
    logic signed [TVEL_W-1:0]   t_vx_q, t_vx_d, t_vy_q, t_vy_d;
    logic        [LIFE_W-1:0]   life_q, life_d;
    logic        [POS_INT_W-1:0] o_x_q, o_x_d, o_y_q, o_y_d, o_tx_q, o_tx_d, o_ty_q, o_ty_d;
    logic        [HDG_W-1:0]    o_hdg_q, o_hdg_d;
    logic                       o_tact_q, o_tact_d;
    logic        [POS_W-1:0]    ship_x_nxt, ship_y_nxt, torp_x_nxt, torp_y_nxt;

    wrap_adder #(.MAX(X_MAX)) u_ship_x (.pos_i(pos_x_q), .vel_i({vel_x_q[VEL_W-1], vel_x_q}), .pos_o(ship_x_nxt));
    wrap_adder #(.MAX(Y_MAX)) u_ship_y (.pos_i(pos_y_q), .vel_i({vel_y_q[VEL_W-1], vel_y_q}), .pos_o(ship_y_nxt));
    wrap_adder #(.MAX(X_MAX)) u_torp_x (.pos_i(t_x_q),   .vel_i(t_vx_q),                      .pos_o(torp_x_nxt));
    wrap_adder #(.MAX(Y_MAX)) u_torp_y (.pos_i(t_y_q),   .vel_i(t_vy_q),                      .pos_o(torp_y_nxt));

    always_comb begin
        state_d  = state_q;
        hdg_d    = hdg_q;
        vel_x_d  = vel_x_q;
        vel_y_d  = vel_y_q;
        pos_x_d  = pos_x_q;
        pos_y_d  = pos_y_q;
        fire_d   = fire_q;
        t_act_d  = t_act_q;
        t_x_d    = t_x_q;
        t_y_d    = t_y_q;
        t_vx_d   = t_vx_q;
        t_vy_d   = t_vy_q;
        life_d   = life_q;
        o_x_d    = o_x_q;
        o_y_d    = o_y_q;
        o_tx_d   = o_tx_q;
        o_ty_d   = o_ty_q;
        o_hdg_d  = o_hdg_q;
        o_tact_d = o_tact_q;
        case (state_q)
            S_IDLE: if (bus.frame_done) state_d = S_ROTATE;
            S_ROTATE: begin
                state_d = S_ACCEL;
                if (bus.rot_left && !bus.rot_right)      hdg_d = hdg_q + HDG_W'(1);
                else if (bus.rot_right && !bus.rot_left) hdg_d = hdg_q - HDG_W'(1);
            end
            S_ACCEL: begin
                state_d = S_MOVE;
                if (bus.thrust) begin
                    vel_x_d = vel_sat(vel_x_q, dir_dx(hdg_q));
                    vel_y_d = vel_sat(vel_y_q, dir_dy(hdg_q));
                end
            end
            S_MOVE: begin
                state_d = S_TORP;
                pos_x_d = ship_x_nxt;
                pos_y_d = ship_y_nxt;
            end
            S_TORP: begin
                state_d = S_DONE;
                fire_d  = bus.fire;
                if (t_act_q) begin
                    t_x_d   = torp_x_nxt;
                    t_y_d   = torp_y_nxt;
                    life_d  = life_q - LIFE_ONE;
                    t_act_d = (life_q != LIFE_ONE);
                end else if (bus.fire && !fire_q) begin
                    t_act_d = 1'b1;
                    t_x_d   = pos_x_q;
                    t_y_d   = pos_y_q;
                    t_vx_d  = torp_vel(dir_dx(hdg_q));
                    t_vy_d  = torp_vel(dir_dy(hdg_q));
                    life_d  = LIFE_INIT;
                end
                // Commit on this edge so the new values appear together with update_done
                o_x_d    = pos_x_q[POS_W-1:POS_FRAC_W];
                o_y_d    = pos_y_q[POS_W-1:POS_FRAC_W];
                o_tx_d   = t_x_d[POS_W-1:POS_FRAC_W];
                o_ty_d   = t_y_d[POS_W-1:POS_FRAC_W];
                o_hdg_d  = hdg_q;
                o_tact_d = t_act_d;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            hdg_q    <= '0;
            vel_x_q  <= '0;
            vel_y_q  <= '0;
            pos_x_q  <= X0;
            pos_y_q  <= Y0;
            fire_q   <= 1'b0;
            t_act_q  <= 1'b0;
            t_x_q    <= '0;
            t_y_q    <= '0;
            t_vx_q   <= '0;
            t_vy_q   <= '0;
            life_q   <= '0;
            o_x_q    <= X0[POS_W-1:POS_FRAC_W];
            o_y_q    <= Y0[POS_W-1:POS_FRAC_W];
            o_tx_q   <= '0;
            o_ty_q   <= '0;
            o_hdg_q  <= '0;
            o_tact_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            hdg_q    <= hdg_d;
            vel_x_q  <= vel_x_d;
            vel_y_q  <= vel_y_d;
            pos_x_q  <= pos_x_d;
            pos_y_q  <= pos_y_d;
            fire_q   <= fire_d;
            t_act_q  <= t_act_d;
            t_x_q    <= t_x_d;
            t_y_q    <= t_y_d;
            t_vx_q   <= t_vx_d;
            t_vy_q   <= t_vy_d;
            life_q   <= life_d;
            o_x_q    <= o_x_d;
            o_y_q    <= o_y_d;
            o_tx_q   <= o_tx_d;
            o_ty_q   <= o_ty_d;
            o_hdg_q  <= o_hdg_d;
            o_tact_q <= o_tact_d;
        end
    end

    assign bus.ship_x      = o_x_q;
    assign bus.ship_y      = o_y_q;
    assign bus.heading     = o_hdg_q;
    assign bus.torp_x      = o_tx_q;
    assign bus.torp_y      = o_ty_q;
    assign bus.torp_active = o_tact_q;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.update_done = (state_q == S_DONE);
endmodule

// File: tb/tb_ship_kinematics.sv
// Scoreboarded bench for ship_kinematics: a frame-level reference model pushes expected outputs
// when each frame is driven; they are popped and compared when update_done appears.
module tb_ship_kinematics;
    localparam int X_SPAN = 640 * 16;
    localparam int Y_SPAN = 480 * 16;

    typedef struct {
        int x; int y; int hdg; int tx; int ty; int tact;
    } exp_t;

    logic clk;
    logic rst;
    ship_kinematics_if sk_if ();

    ship_kinematics #(
        .X_MAX(640), .Y_MAX(480), .START_X(320), .START_Y(240), .TORP_LIFE(64)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(sk_if)
    );

    logic        [13:0] wa_pos;
    logic signed [8:0]  wa_vel;
    logic        [13:0] wa_out;
    wrap_adder #(.MAX(640)) u_wa (.pos_i(wa_pos), .vel_i(wa_vel), .pos_o(wa_out));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t exp_q[$];
    exp_t last_e;

    int DX[16] = '{4, 4, 3, 2, 0, -2, -3, -4, -4, -4, -3, -2, 0, 2, 3, 4};
    int DY[16] = '{0, -2, -3, -4, -4, -4, -3, -2, 0, 2, 3, 4, 4, 4, 3, 2};

    int m_hdg, m_vx, m_vy, m_px, m_py, m_tx, m_ty, m_tvx, m_tvy, m_life;
    bit m_fireq, m_tact;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int wrapm(input int v, input int span);
        return ((v % span) + span) % span;
    endfunction

    function automatic int clampv(input int v);
        if (v > 63)  return 63;
        if (v < -64) return -64;
        return v;
    endfunction

    function automatic exp_t snap();
        exp_t e;
        e.x = m_px / 16;  e.y = m_py / 16;  e.hdg = m_hdg;
        e.tx = m_tx / 16; e.ty = m_ty / 16; e.tact = int'(m_tact);
        return e;
    endfunction

    task automatic model_reset();
        m_hdg = 0; m_vx = 0; m_vy = 0; m_px = 320 * 16; m_py = 240 * 16;
        m_tx = 0; m_ty = 0; m_tvx = 0; m_tvy = 0; m_life = 0;
        m_fireq = 1'b0; m_tact = 1'b0;
        last_e = snap();
    endtask

    task automatic model_step(input bit rl, input bit rr, input bit th, input bit fi);
        bit fedge;
        if (rl && !rr)      m_hdg = (m_hdg + 1) % 16;
        else if (rr && !rl) m_hdg = (m_hdg + 15) % 16;
        if (th) begin
            m_vx = clampv(m_vx + DX[m_hdg]);
            m_vy = clampv(m_vy + DY[m_hdg]);
        end
        m_px = wrapm(m_px + m_vx, X_SPAN);
        m_py = wrapm(m_py + m_vy, Y_SPAN);
        fedge = fi && !m_fireq;
        m_fireq = fi;
        if (m_tact) begin
            m_tx = wrapm(m_tx + m_tvx, X_SPAN);
            m_ty = wrapm(m_ty + m_tvy, Y_SPAN);
            m_life--;
            if (m_life == 0) m_tact = 1'b0;
        end else if (fedge) begin
            m_tact = 1'b1;
            m_tx = m_px; m_ty = m_py;
            m_tvx = DX[m_hdg] * 16; m_tvy = DY[m_hdg] * 16;
            m_life = 64;
        end
    endtask

    task automatic run_frame(input bit rl, input bit rr, input bit th, input bit fi, input bit spur);
        exp_t e;
        int   cyc;
        sk_if.rot_left = rl; sk_if.rot_right = rr; sk_if.thrust = th; sk_if.fire = fi;
        model_step(rl, rr, th, fi);
        exp_q.push_back(snap());
        sk_if.frame_done = 1'b1;
        @(negedge clk);
        sk_if.frame_done = 1'b0;
        cyc = 1;
        while (!sk_if.update_done && cyc < 20) begin
            check_eq("hold_ship_x", int'(sk_if.ship_x), last_e.x);
            check_eq("hold_torp_active", int'(sk_if.torp_active), last_e.tact);
            check_eq("busy_in_update", int'(sk_if.busy), 1);
            sk_if.frame_done = spur && (cyc == 2);
            @(negedge clk);
            cyc++;
        end
        sk_if.frame_done = 1'b0;
        check_eq("latency", cyc, 5);
        e = exp_q.pop_front();
        check_eq("ship_x", int'(sk_if.ship_x), e.x);
        check_eq("ship_y", int'(sk_if.ship_y), e.y);
        check_eq("heading", int'(sk_if.heading), e.hdg);
        check_eq("torp_active", int'(sk_if.torp_active), e.tact);
        if (e.tact != 0) begin
            check_eq("torp_x", int'(sk_if.torp_x), e.tx);
            check_eq("torp_y", int'(sk_if.torp_y), e.ty);
        end
        check_eq("busy_done", int'(sk_if.busy), 1);
        last_e = e;
        @(negedge clk);
        check_eq("idle_busy", int'(sk_if.busy), 0);
        check_eq("idle_update_done", int'(sk_if.update_done), 0);
    endtask

    task automatic idle_window(input int n);
        int pulses = 0;
        repeat (n) begin
            @(negedge clk);
            if (sk_if.update_done) pulses++;
        end
        check_eq("no_extra_update", pulses, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ship_x"}, int'(sk_if.ship_x), 320);
        check_eq({tag, "_ship_y"}, int'(sk_if.ship_y), 240);
        check_eq({tag, "_heading"}, int'(sk_if.heading), 0);
        check_eq({tag, "_torp_active"}, int'(sk_if.torp_active), 0);
        check_eq({tag, "_torp_x"}, int'(sk_if.torp_x), 0);
        check_eq({tag, "_torp_y"}, int'(sk_if.torp_y), 0);
        check_eq({tag, "_busy"}, int'(sk_if.busy), 0);
        check_eq({tag, "_update_done"}, int'(sk_if.update_done), 0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int wa_p[4] = '{10239, 0, 5000, 10200};
        int wa_v[4] = '{2, -1, 63, 64};
        int xa, xb;

        rst = 1'b0;
        sk_if.frame_done = 1'b0; sk_if.rot_left = 1'b0; sk_if.rot_right = 1'b0;
        sk_if.thrust = 1'b0; sk_if.fire = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");

        for (int i = 0; i < 4; i++) begin
            wa_pos = 14'(wa_p[i]);
            wa_vel = 9'(wa_v[i]);
            #1;
            check_eq("wrap_adder", int'(wa_out), wrapm(wa_p[i] + wa_v[i], X_SPAN));
        end
        check_eq("wrap_edge_px", int'(wa_out[13:4]), wrapm(10200 + 64, X_SPAN) / 16);

        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        repeat (3) run_frame(0, 0, 0, 0, 0);
        run_frame(0, 0, 0, 0, 1);
        idle_window(8);

        repeat (20) run_frame(0, 0, 1, 0, 0);
        xa = int'(sk_if.ship_x);
        run_frame(0, 0, 0, 0, 0);
        xb = int'(sk_if.ship_x);
        check_eq("coast_step_3_or_4", int'(((xb - xa + 640) % 640) inside {3, 4}), 1);
        repeat (85) run_frame(0, 0, 0, 0, 0);

        run_frame(0, 0, 0, 1, 0);
        xa = int'(sk_if.torp_x);
        run_frame(0, 0, 0, 1, 0);
        xb = int'(sk_if.torp_x);
        check_eq("torp_step_4px", (xb - xa + 640) % 640, 4);
        run_frame(0, 0, 0, 0, 0);
        run_frame(0, 0, 0, 1, 0);
        repeat (64) run_frame(0, 0, 0, 0, 0);
        run_frame(0, 0, 0, 1, 0);
        repeat (3) run_frame(0, 0, 0, 0, 0);

        repeat (17) run_frame(1, 0, 0, 0, 0);
        repeat (2) run_frame(1, 1, 0, 0, 0);
        run_frame(0, 1, 0, 0, 0);
        repeat (8) run_frame(1, 0, 0, 0, 0);
        repeat (40) run_frame(0, 0, 1, 0, 0);
        repeat (170) run_frame(0, 0, 0, 0, 0);
        repeat (4) run_frame(1, 0, 0, 0, 0);
        repeat (10) run_frame(0, 0, 1, 0, 0);
        repeat (2) run_frame(1, 0, 0, 0, 0);
        repeat (6) run_frame(0, 0, 1, 1, 0);
        repeat (20) run_frame(0, 0, 0, 0, 0);

        sk_if.thrust = 1'b1;
        sk_if.frame_done = 1'b1;
        @(negedge clk);
        sk_if.frame_done = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_outputs("midreset");
        sk_if.thrust = 1'b0;
        idle_window(8);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        run_frame(0, 0, 1, 0, 0);
        run_frame(1, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
